// File: rtl/unsigned_exchange_pkg.sv
// Shared definitions for the unsigned exchange (approximate multiply / divide) family.
package unsigned_exchange_pkg;

    localparam int Z_W       = 16;
    localparam int Y_W       = 8;
    localparam int X_W       = 8;
    localparam int L_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Clear the low l dividend bits so results line up with the truncated-column multipliers.
    function automatic logic [Z_W-1:0] condition_dividend(input logic [Z_W-1:0] z, input int unsigned l);
        return z & ({Z_W{1'b1}} << l);
    endfunction

endpackage

// File: rtl/unsigned_div_step_8.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module unsigned_div_step_8
    import unsigned_exchange_pkg::*;
(
    input  logic [Y_W:0]   i_rem,
    input  logic           i_bit,
    input  logic [Y_W-1:0] i_y,
    output logic [Y_W:0]   o_rem,
    output logic           o_q
);

    logic [Y_W:0] w_t;
    logic         w_ge;
    logic         w_unused_rem_msb;

    // The incoming remainder is always below y, so its MSB never carries information.
    assign w_unused_rem_msb = i_rem[Y_W];
    assign w_t   = {i_rem[Y_W-1:0], i_bit};
    assign w_ge  = (w_t >= {1'b0, i_y});
    assign o_rem = w_ge ? (w_t - {1'b0, i_y}) : w_t;
    assign o_q   = w_ge;

endmodule

// File: rtl/unsigned_exchange_div_16by8_l4.sv
// Iterative 16/8 restoring divider with low-bit dividend truncation and valid/ready handshakes.
module unsigned_exchange_div_16by8_l4
    import unsigned_exchange_pkg::*;
#(
    parameter int L = L_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Z_W-1:0] z,
    input  logic [Y_W-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] r,
    output logic           ovf,
    output logic           dz
);

    div_state_e     r_state, w_state;
    logic [Y_W:0]   r_rem, w_rem;
    logic [X_W-1:0] r_q, w_q;
    logic [7:0]     r_sh, w_sh;
    logic [2:0]     r_cnt, w_cnt;
    logic [Y_W-1:0] r_y, w_y;
    logic           r_in_ready, w_in_ready;
    logic           r_out_valid, w_out_valid;
    logic [X_W-1:0] r_x, w_x;
    logic [Y_W-1:0] r_r, w_r;
    logic           r_ovf, w_ovf;
    logic           r_dz, w_dz;

    logic [Z_W-1:0] w_z_eff;
    logic [Y_W:0]   w_step_rem;
    logic           w_step_q;

    assign w_z_eff = condition_dividend(z, L);

    unsigned_div_step_8 u_step (
        .i_rem (r_rem),
        .i_bit (r_sh[7]),
        .i_y   (r_y),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_q     = r_q;
        w_sh    = r_sh;
        w_cnt   = r_cnt;
        w_y     = r_y;
        w_x     = r_x;
        w_r     = r_r;
        w_ovf   = r_ovf;
        w_dz    = r_dz;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_y = y;
                    if (y == 8'd0) begin
                        w_state = DONE;
                        w_dz    = 1'b1;
                        w_ovf   = 1'b0;
                        w_x     = 8'hFF;
                        w_r     = 8'h00;
                    end else if (w_z_eff[15:8] >= y) begin
                        // Quotient would need a ninth bit.
                        w_state = DONE;
                        w_dz    = 1'b0;
                        w_ovf   = 1'b1;
                        w_x     = 8'hFF;
                        w_r     = 8'h00;
                    end else begin
                        w_state = CALC;
                        w_rem   = {1'b0, w_z_eff[15:8]};
                        w_sh    = w_z_eff[7:0];
                        w_q     = 8'd0;
                        w_cnt   = 3'd7;
                    end
                end else begin
                    w_state = IDLE;
                end
            end
            CALC: begin
                w_rem = w_step_rem;
                w_q   = {r_q[6:0], w_step_q};
                w_sh  = {r_sh[6:0], 1'b0};
                if (r_cnt == 3'd0) begin
                    w_state = DONE;
                    w_x     = {r_q[6:0], w_step_q};
                    w_r     = w_step_rem[7:0];
                    w_ovf   = 1'b0;
                    w_dz    = 1'b0;
                end else begin
                    w_cnt = r_cnt - 3'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state = IDLE;
                end else begin
                    w_state = DONE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        w_in_ready  = (w_state == IDLE);
        w_out_valid = (w_state == DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= 9'd0;
            r_q         <= 8'd0;
            r_sh        <= 8'd0;
            r_cnt       <= 3'd0;
            r_y         <= 8'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_x         <= 8'd0;
            r_r         <= 8'd0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_rem       <= w_rem;
            r_q         <= w_q;
            r_sh        <= w_sh;
            r_cnt       <= w_cnt;
            r_y         <= w_y;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_x         <= w_x;
            r_r         <= w_r;
            r_ovf       <= w_ovf;
            r_dz        <= w_dz;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign x         = r_x;
    assign r         = r_r;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

endmodule

// File: tb/tb_unsigned_exchange_div_16by8_l4.sv
// Randomised and directed bench for the exchange divider; L=4 and L=0 instances share stimulus.
module tb_unsigned_exchange_div_16by8_l4;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, sel;
    logic [15:0] z;
    logic [7:0]  y;

    logic        a_iv, a_ordy, a_in_ready, a_out_valid, a_ovf, a_dz;
    logic [7:0]  a_x, a_r;
    logic        b_iv, b_ordy, b_in_ready, b_out_valid, b_ovf, b_dz;
    logic [7:0]  b_x, b_r;
    logic        m_in_ready, m_out_valid, m_out_ready, m_ovf, m_dz;
    logic [7:0]  m_x, m_r;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] r;
        logic       ovf;
        logic       dz;
        int         ze;
        int         yv;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign a_iv   = in_valid & ~sel;
    assign a_ordy = out_ready & ~sel;
    assign b_iv   = in_valid & sel;
    assign b_ordy = out_ready & sel;

    unsigned_exchange_div_16by8_l4 #(.L(4)) dut_l4 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_in_ready), .z(z), .y(y),
        .out_valid(a_out_valid), .out_ready(a_ordy), .x(a_x), .r(a_r), .ovf(a_ovf), .dz(a_dz)
    );

    unsigned_exchange_div_16by8_l4 #(.L(0)) dut_l0 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_in_ready), .z(z), .y(y),
        .out_valid(b_out_valid), .out_ready(b_ordy), .x(b_x), .r(b_r), .ovf(b_ovf), .dz(b_dz)
    );

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_ready = sel ? b_ordy      : a_ordy;
    assign m_x         = sel ? b_x         : a_x;
    assign m_r         = sel ? b_r         : a_r;
    assign m_ovf       = sel ? b_ovf       : a_ovf;
    assign m_dz        = sel ? b_dz        : a_dz;

    // Reference: plain integer division of the truncated dividend.
    function automatic exp_t model(input logic [15:0] zz, input logic [7:0] yy, input int l);
        exp_t e;
        int   q;
        e.ze  = (int'(zz) >> l) << l;
        e.yv  = int'(yy);
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        e.x   = 8'hFF;
        e.r   = 8'h00;
        if (yy == 8'd0) begin
            e.dz = 1'b1;
        end else begin
            q = e.ze / e.yv;
            if (q > 255) begin
                e.ovf = 1'b1;
            end else begin
                e.x = 8'(q);
                e.r = 8'(e.ze % e.yv);
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle a result is presented, compare it with the head of the expectation queue.
    always @(posedge clk) begin
        exp_t e;
        if (!rst && m_out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q[0];
                check("x", int'(m_x), int'(e.x));
                check("r", int'(m_r), int'(e.r));
                check("ovf", int'(m_ovf), int'(e.ovf));
                check("dz", int'(m_dz), int'(e.dz));
                check("in_ready_busy", int'(m_in_ready), 0);
                if (!e.ovf && !e.dz) begin
                    check("x*y+r", int'(m_x) * e.yv + int'(m_r), e.ze);
                    check("r<y", int'(int'(m_r) < e.yv), 1);
                end
                if (m_out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] zz, input logic [7:0] yy, input int exp_lat, input int stall);
        int n;
        @(negedge clk);
        z         = zz;
        y         = yy;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!m_in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", int'(m_in_ready), 1);
        exp_q.push_back(model(zz, yy, sel ? 0 : 4));
        @(posedge clk);
        #1;
        // Keep in_valid high with junk operands: must be ignored until in_ready returns.
        z = 16'($urandom);
        y = 8'($urandom);
        n = 1;
        while (!m_out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, exp_lat);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", int'(m_out_valid), 0);
        check("in_ready_back", int'(m_in_ready), 1);
    endtask

    task automatic run_random(input int count);
        logic [7:0]  yy;
        logic [7:0]  hi;
        logic [15:0] zz;
        for (int i = 0; i < count; i++) begin
            yy = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, int'(yy) - 1));
            zz = {hi, 8'($urandom)};
            run_op(zz, yy, 9, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t pin;
        sel       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        z         = 16'd0;
        y         = 8'd0;

        pin = model(16'h1234, 8'h13, 4);
        check("model_1234_x", int'(pin.x), 'hF5);
        check("model_1234_r", int'(pin.r), 'h01);
        pin = model(16'h00C8, 8'h07, 0);
        check("model_00c8_l0_x", int'(pin.x), 'h1C);
        pin = model(16'hFFFF, 8'hFF, 4);
        check("model_ffff_ovf", int'(pin.ovf), 1);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_a_in_ready", int'(a_in_ready), 1);
        check("rst_a_out_valid", int'(a_out_valid), 0);
        check("rst_a_x", int'(a_x), 0);
        check("rst_a_r", int'(a_r), 0);
        check("rst_a_flags", int'({a_ovf, a_dz}), 0);
        check("rst_b_in_ready", int'(b_in_ready), 1);
        check("rst_b_out_valid", int'(b_out_valid), 0);

        run_op(16'h1234, 8'h13, 9, 0);
        check("d1_x", int'(m_x), 'hF5);
        check("d1_r", int'(m_r), 'h01);
        run_op(16'h00C8, 8'h07, 9, 0);
        check("d2_x", int'(m_x), 'h1B);
        check("d2_r", int'(m_r), 'h03);
        run_op(16'hFFFF, 8'hFF, 1, 0);
        check("ovf_flag", int'(m_ovf), 1);
        check("ovf_x", int'(m_x), 'hFF);
        run_op(16'h0100, 8'h00, 1, 0);
        check("dz_flag", int'(m_dz), 1);
        check("dz_r", int'(m_r), 0);
        run_op(16'hFFFF, 8'h00, 1, 0);
        check("dz_priority", int'({m_dz, m_ovf}), 2);
        run_op(16'h1234, 8'h13, 9, 5);

        sel = 1'b1;
        run_op(16'h00C8, 8'h07, 9, 0);
        check("l0_x", int'(m_x), 'h1C);
        check("l0_r", int'(m_r), 'h04);

        // Abort in the fourth CALC cycle.
        @(negedge clk);
        z        = 16'h0500;
        y        = 8'h20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", int'(m_out_valid), 0);
        check("abort_x", int'(m_x), 0);
        check("abort_r", int'(m_r), 0);
        check("abort_in_ready", int'(m_in_ready), 1);
        run_op(16'h0064, 8'h0A, 9, 0);
        check("post_abort_x", int'(m_x), 'h0A);
        check("post_abort_r", int'(m_r), 'h00);

        run_random(1500);
        sel = 1'b0;
        run_random(1500);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
